// File: rtl/ex_hazard_sched.sv
// ex_hazard_sched -- execute-stage hazard scheduler.
//
// Purpose: tracks the destination registers of the instructions in EX, MEM
// and WB, drives the operand forwarding selects into execute, stalls ID for
// one cycle on a load-use hazard, and sequences multi-cycle EX operations
// (MUL/DIV) by holding EX and bubbling MEM until the op has spent MC_CYCLES
// cycles in EX.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   id_*                  decoded fields of the instruction currently in ID
//   flush                 taken branch/jump in EX; kills the ID instruction
//   stall_id              hold PC and IF/ID register
//   ex_hold               hold ID/EX register (multi-cycle op in progress)
//   bubble_mem            write a bubble into EX/MEM
//   fwd_left / fwd_right  forwarding selects for operand A / operand B
//   busy                  scheduler is in the multi-cycle busy state

package ex_hazard_sched_pkg;
    typedef enum logic [1:0] {
        NONE   = 2'b00,
        EX_MEM = 2'b01,
        MEM_WB = 2'b10
    } forwarding_type;
endpackage

module ex_hazard_sched
    import ex_hazard_sched_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_CYCLES      = 4,
    parameter int CNT_WIDTH      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_multicycle,
    input  logic                      flush,
    output logic                      stall_id,
    output logic                      ex_hold,
    output logic                      bubble_mem,
    output forwarding_type            fwd_left,
    output forwarding_type            fwd_right,
    output logic                      busy
);

    typedef enum logic {RUN, MC_BUSY} state_t;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      mem_read;
        logic                      multicycle;
    } ex_entry_t;

    // MEM and WB only need to know what they will write back.
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
    } wr_entry_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    ex_entry_t            ex_q,    ex_d;
    wr_entry_t            mem_q,   mem_d;
    wr_entry_t            wb_q,    wb_d;

    logic                 load_use;

    // Forwarding select for one EX source. The younger producer (MEM) wins.
    function automatic forwarding_type fwd_sel(input logic [REG_ADDR_WIDTH-1:0] src);
        forwarding_type sel;
        sel = NONE;
        if (mem_q.valid && mem_q.reg_write && (mem_q.rd != '0) && (mem_q.rd == src))
            sel = EX_MEM;
        else if (wb_q.valid && wb_q.reg_write && (wb_q.rd != '0) && (wb_q.rd == src))
            sel = MEM_WB;
        return sel;
    endfunction

    always_comb begin
        fwd_left  = NONE;
        fwd_right = NONE;
        if (ex_q.valid) begin
            fwd_left  = fwd_sel(ex_q.rs1);
            fwd_right = fwd_sel(ex_q.rs2);
        end
    end

    // A load in EX whose result the ID instruction needs cannot be forwarded
    // in time; ID waits one cycle so the value can come from MEM/WB instead.
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                      ((id_rs1 == ex_q.rd) || (id_uses_rs2 && (id_rs2 == ex_q.rd)));

    assign busy = (state_q == MC_BUSY);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_d       = ex_q;
        mem_d      = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
        wb_d       = mem_q;
        stall_id   = 1'b0;
        ex_hold    = 1'b0;
        bubble_mem = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_q.valid && ex_q.multicycle) begin
                    // First EX cycle of a multi-cycle op: freeze EX and ID,
                    // feed MEM a bubble. Takes priority over flush/load-use.
                    ex_hold     = 1'b1;
                    stall_id    = 1'b1;
                    bubble_mem  = 1'b1;
                    mem_d.valid = 1'b0;
                    if (MC_CYCLES > 2) begin
                        state_d = MC_BUSY;
                        cnt_d   = CNT_WIDTH'(MC_CYCLES - 2);
                    end else begin
                        // Two-cycle op: a single hold cycle is enough.
                        ex_d.multicycle = 1'b0;
                    end
                end else begin
                    stall_id        = load_use && !flush;
                    ex_d.valid      = id_valid && !flush && !load_use;
                    ex_d.rs1        = id_rs1;
                    ex_d.rs2        = id_rs2;
                    ex_d.rd         = id_rd;
                    ex_d.reg_write  = id_reg_write;
                    ex_d.mem_read   = id_mem_read;
                    ex_d.multicycle = id_multicycle;
                end
            end
            MC_BUSY: begin
                // flush is ignored here: EX holds a MUL/DIV, not a branch.
                ex_hold     = 1'b1;
                stall_id    = 1'b1;
                bubble_mem  = 1'b1;
                mem_d.valid = 1'b0;
                cnt_d       = cnt_q - CNT_WIDTH'(1);
                // Counter drains to 0 on the last busy cycle. Clearing the
                // multicycle flag lets the op leave EX on the following (RUN)
                // cycle, giving exactly MC_CYCLES cycles of EX occupancy.
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d         = RUN;
                    ex_d.multicycle = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

endmodule

// File: tb/tb_ex_hazard_sched.sv
// Self-checking bench for ex_hazard_sched: directed scenarios followed by
// randomized traffic, all compared against a per-instruction pipeline model.
module tb_ex_hazard_sched;
    import ex_hazard_sched_pkg::*;

    localparam int MC = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           id_valid = 1'b0;
    logic [4:0]     id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic           id_uses_rs2 = 1'b0, id_reg_write = 1'b0;
    logic           id_mem_read = 1'b0, id_multicycle = 1'b0, flush = 1'b0;
    logic           stall_id, ex_hold, bubble_mem, busy;
    forwarding_type fwd_left, fwd_right;

    always #5 clk = ~clk;

    ex_hazard_sched #(.REG_ADDR_WIDTH(5), .MC_CYCLES(MC), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_multicycle(id_multicycle), .flush(flush),
        .stall_id(stall_id), .ex_hold(ex_hold), .bubble_mem(bubble_mem),
        .fwd_left(fwd_left), .fwd_right(fwd_right), .busy(busy)
    );

    always @(negedge clk)
        if (rst_n) assert (!(busy && flush)) else $error("flush driven while busy");

    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       u2, rw, mr, mc;
    } ins_t;

    // Model: one record per pipeline slot, plus how many cycles the EX
    // instruction has occupied EX so far.
    ins_t m_ex, m_mem, m_wb;
    int   m_age;

    int n_chk = 0, n_err = 0;
    int o_stall, o_hold, o_bub, o_busy, o_fl, o_fr;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic ins_t mk(input bit v, input int rd, input int rs1, input int rs2,
                                input bit u2, input bit rw, input bit mr, input bit mc);
        ins_t i;
        i.v = v; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
        i.u2 = u2; i.rw = rw; i.mr = mr; i.mc = mc;
        return i;
    endfunction

    function automatic int m_fwd(input bit [4:0] src);
        if (!m_ex.v) return 0;
        if (m_mem.v && m_mem.rw && m_mem.rd != 0 && m_mem.rd == src) return 1;
        if (m_wb.v && m_wb.rw && m_wb.rd != 0 && m_wb.rd == src) return 2;
        return 0;
    endfunction

    function automatic bit m_holding();
        return m_ex.v && m_ex.mc && (m_age < MC);
    endfunction

    task automatic m_reset();
        m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
        m_age = 0;
    endtask

    // One clock cycle: drive ID, check outputs against the model, advance.
    // Entered and left at posedge+1.
    task automatic cyc(input ins_t id, input bit fl);
        bit hold, lu;
        id_valid = id.v; id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
        id_uses_rs2 = id.u2; id_reg_write = id.rw; id_mem_read = id.mr;
        id_multicycle = id.mc; flush = fl;
        #2;
        hold = m_holding();
        lu = !hold && m_ex.v && m_ex.mr && m_ex.rd != 0 && id.v &&
             (id.rs1 == m_ex.rd || (id.u2 && id.rs2 == m_ex.rd));
        o_stall = int'(stall_id); o_hold = int'(ex_hold); o_bub = int'(bubble_mem);
        o_busy = int'(busy); o_fl = int'(fwd_left); o_fr = int'(fwd_right);
        chk("stall_id",   o_stall, int'(hold || (lu && !fl)));
        chk("ex_hold",    o_hold,  int'(hold));
        chk("bubble_mem", o_bub,   int'(hold));
        chk("busy",       o_busy,  int'(hold && m_age >= 2));
        chk("fwd_left",   o_fl,    m_fwd(m_ex.rs1));
        chk("fwd_right",  o_fr,    m_fwd(m_ex.rs2));
        m_wb = m_mem;
        if (hold) begin
            m_mem.v = 0;
            m_age++;
        end else begin
            m_mem = m_ex;
            m_ex = id;
            m_ex.v = id.v && !fl && !lu;
            m_age = 1;
        end
        @(posedge clk); #1;
    endtask

    ins_t nop, r_id;
    bit   fl;
    bit [3:0] hold_pat, busy_pat;
    int   fwd_seq [3];

    initial begin
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", int'(stall_id), 0);
        chk("rst_hold",  int'(ex_hold), 0);
        chk("rst_bub",   int'(bubble_mem), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_fwd",   int'(fwd_left) + int'(fwd_right), 0);
        rst_n = 1'b1;

        // Forwarding priority: MEM and WB both write x1.
        cyc(mk(1, 1, 0, 0, 0, 1, 0, 0), 0);
        cyc(mk(1, 1, 0, 0, 0, 1, 0, 0), 0);
        cyc(mk(1, 3, 1, 2, 1, 1, 0, 0), 0);
        cyc(nop, 0);
        chk("prio_left", o_fl, 1);
        chk("prio_right", o_fr, 0);
        // Same with MEM invalid -> WB forwards.
        cyc(mk(1, 1, 0, 0, 0, 1, 0, 0), 0);
        cyc(nop, 0);
        cyc(mk(1, 3, 1, 2, 1, 1, 0, 0), 0);
        cyc(nop, 0);
        chk("memwb_left", o_fl, 2);

        // Load-use: lw x5; add x6,x5,x7.
        cyc(mk(1, 5, 0, 0, 0, 1, 1, 0), 0);
        cyc(mk(1, 6, 5, 7, 1, 1, 0, 0), 0);
        chk("lu_stall", o_stall, 1);
        cyc(mk(1, 6, 5, 7, 1, 1, 0, 0), 0);
        chk("lu_once", o_stall, 0);
        cyc(nop, 0);
        chk("lu_fwd", o_fl, 2);

        // x0 guard.
        cyc(mk(1, 0, 0, 0, 0, 1, 1, 0), 0);
        cyc(mk(1, 6, 0, 0, 1, 1, 0, 0), 0);
        chk("x0_stall", o_stall, 0);
        cyc(nop, 0);
        chk("x0_fwd", o_fl, 0);

        // Flush beats load-use.
        cyc(mk(1, 5, 0, 0, 0, 1, 1, 0), 0);
        cyc(mk(1, 6, 5, 7, 1, 1, 0, 0), 1);
        chk("fl_stall", o_stall, 0);
        cyc(nop, 0);
        chk("fl_exbub", o_fl, 0);

        // Multi-cycle: add x4; div x11,x4,x4; dependent add waits in ID.
        cyc(mk(1, 4, 0, 0, 0, 1, 0, 0), 0);
        cyc(mk(1, 11, 4, 4, 1, 1, 0, 1), 0);
        for (int k = 0; k < 4; k++) begin
            cyc(mk(1, 12, 11, 0, 0, 1, 0, 0), 0);
            hold_pat[k] = o_hold[0];
            busy_pat[k] = o_busy[0];
            if (k < 3) fwd_seq[k] = o_fl;
        end
        chk("mc_hold_pat", int'(hold_pat), 4'b0111);
        chk("mc_busy_pat", int'(busy_pat), 4'b0110);
        chk("mc_fwd0", fwd_seq[0], 1);
        chk("mc_fwd1", fwd_seq[1], 2);
        chk("mc_fwd2", fwd_seq[2], 0);
        cyc(nop, 0);
        chk("mc_div_in_mem", o_fl, 1);

        // Async reset in the middle of a busy period.
        cyc(mk(1, 9, 1, 2, 1, 1, 0, 1), 0);
        cyc(nop, 0);
        cyc(nop, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_hold", int'(ex_hold), 0);
        chk("arst_stall", int'(stall_id), 0);
        chk("arst_fwd", int'(fwd_left) + int'(fwd_right), 0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(mk(1, 9, 1, 2, 1, 1, 0, 1), 0);
        cyc(nop, 0);
        chk("arst_newop", o_hold, 1);

        // Randomized traffic; a stalled ID instruction is re-presented.
        r_id = nop;
        for (int n = 0; n < 3000; n++) begin
            fl = 0;
            if (!m_holding() && m_ex.v && !m_ex.mc) fl = ($urandom_range(0, 15) == 0);
            if (o_stall == 0 || fl)
                r_id = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            cyc(r_id, fl);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
